poc_bus_arbiter: RTL and testbench

Two-master arbiter for the POC register bus (rw, reg_in, addr, data_out, reg_out, irq). It sits between two processor-style masters and one POC. It grants the bus round-robin, with optional lock and a hold-time limit, and inserts a one-cycle idle gap between owners. It also routes the active-low POC interrupt to whichever master last put the POC into interrupt mode.

---
 rtl/poc_bus_arbiter.sv | 134 +++++++++++++
 tb/tb_poc_bus_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/poc_bus_arbiter.sv
// Two-master round-robin arbiter for the POC register bus with lock, hold-time
// limit, a one-cycle idle gap between owners and interrupt routing to the mode owner.
module poc_bus_arbiter #(
  parameter int unsigned HOLD_MAX = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m0_req,
  input  logic       m1_req,
  input  logic       m0_lock,
  input  logic       m1_lock,
  input  logic       m0_rw,
  input  logic       m1_rw,
  input  logic [2:0] m0_addr,
  input  logic [2:0] m1_addr,
  input  logic       m0_reg_in,
  input  logic       m1_reg_in,
  input  logic [7:0] m0_data,
  input  logic [7:0] m1_data,
  output logic       m0_gnt,
  output logic       m1_gnt,
  output logic       m0_reg_out,
  output logic       m1_reg_out,
  output logic       m0_irq,
  output logic       m1_irq,
  output logic       rw,
  output logic       reg_in,
  output logic [2:0] addr,
  output logic [7:0] data_out,
  input  logic       reg_out,
  input  logic       irq
);

  localparam int unsigned CW = $clog2(HOLD_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GAP} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          last;
  logic [CW-1:0] hold_cnt;
  logic          own_valid;
  logic          own_id;

  logic          granted;
  logic          cur_id;
  logic          cur_req;
  logic          cur_lock;
  logic          cur_rw;
  logic [2:0]    cur_addr;
  logic          cur_reg_in;
  logic [7:0]    cur_data;
  logic          other_req;
  logic          drop;
  logic          fwd;
  logic          pick1;

  // Select the current owner's signals and decide the next state.
  always_comb begin
    granted    = (state == GNT0) || (state == GNT1);
    cur_id     = (state == GNT1);
    cur_req    = cur_id ? m1_req    : m0_req;
    cur_lock   = cur_id ? m1_lock   : m0_lock;
    cur_rw     = cur_id ? m1_rw     : m0_rw;
    cur_addr   = cur_id ? m1_addr   : m0_addr;
    cur_reg_in = cur_id ? m1_reg_in : m0_reg_in;
    cur_data   = cur_id ? m1_data   : m0_data;
    other_req  = cur_id ? m0_req    : m1_req;
    drop       = granted && !cur_lock &&
                 (!cur_req || ((hold_cnt == CNT_MAX) && other_req));
    fwd        = granted && cur_req;
    pick1      = m1_req && (!m0_req || !last);
    state_nxt  = state;
    case (state)
      IDLE, GAP: begin
        if (m0_req || m1_req) state_nxt = pick1 ? GNT1 : GNT0;
        else                  state_nxt = IDLE;
      end
      default: begin
        if (drop) state_nxt = GAP;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      hold_cnt  <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      rw        <= 1'b0;
      reg_in    <= 1'b0;
      addr      <= 3'd0;
      data_out  <= 8'd0;
      own_valid <= 1'b0;
      own_id    <= 1'b0;
    end else begin
      state  <= state_nxt;
      m0_gnt <= (state_nxt == GNT0);
      m1_gnt <= (state_nxt == GNT1);

      if (!granted && (m0_req || m1_req)) begin
        last     <= pick1;
        hold_cnt <= '0;
      end else if (granted && (hold_cnt != CNT_MAX)) begin
        hold_cnt <= hold_cnt + CW'(1);
      end

      // Only the granted, requesting master reaches the POC; data_out holds when idle.
      if (fwd) begin
        rw       <= cur_rw;
        reg_in   <= cur_reg_in;
        addr     <= cur_addr;
        data_out <= cur_data;
        if (cur_rw && (cur_addr == 3'd0)) begin
          own_valid <= cur_reg_in;
          if (cur_reg_in) own_id <= cur_id;
        end
      end else begin
        rw     <= 1'b0;
        reg_in <= 1'b0;
        addr   <= 3'd0;
      end
    end
  end

  assign m0_reg_out = reg_out & m0_gnt;
  assign m1_reg_out = reg_out & m1_gnt;
  assign m0_irq     = (own_valid && !own_id) ? irq : 1'b1;
  assign m1_irq     = (own_valid &&  own_id) ? irq : 1'b1;

endmodule

// File: tb/tb_poc_bus_arbiter.sv
// Bench for poc_bus_arbiter: directed scenarios plus random traffic, all checked
// every cycle against an ownership-level model of the arbiter.
module tb_poc_bus_arbiter;

  localparam int unsigned HOLD_MAX = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       req   [2];
  logic       lock  [2];
  logic       rw_i  [2];
  logic       regin [2];
  logic [2:0] addr_i[2];
  logic [7:0] data_i[2];
  logic       reg_out;
  logic       irq;

  logic       m0_gnt, m1_gnt, m0_reg_out, m1_reg_out, m0_irq, m1_irq;
  logic       rw, reg_in;
  logic [2:0] addr;
  logic [7:0] data_out;

  always #5 clk = ~clk;

  poc_bus_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m1_req(req[1]),
    .m0_lock(lock[0]), .m1_lock(lock[1]),
    .m0_rw(rw_i[0]), .m1_rw(rw_i[1]),
    .m0_addr(addr_i[0]), .m1_addr(addr_i[1]),
    .m0_reg_in(regin[0]), .m1_reg_in(regin[1]),
    .m0_data(data_i[0]), .m1_data(data_i[1]),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_reg_out(m0_reg_out), .m1_reg_out(m1_reg_out),
    .m0_irq(m0_irq), .m1_irq(m1_irq),
    .rw(rw), .reg_in(reg_in), .addr(addr), .data_out(data_out),
    .reg_out(reg_out), .irq(irq)
  );

  // Model: who owns the bus (-1 = nobody), cycles held, tie-break memory, POC pins, irq owner.
  int         m_owner;
  bit         m_last;
  int         m_held;
  logic       e_rw, e_regin;
  logic [2:0] e_addr;
  logic [7:0] e_data;
  bit         o_valid, o_id;

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_owner = -1; m_last = 1'b1; m_held = 0;
      e_rw = 1'b0; e_regin = 1'b0; e_addr = 3'd0; e_data = 8'd0;
      o_valid = 1'b0; o_id = 1'b0;
    end else begin
      int o;
      o = m_owner;
      if (o >= 0 && req[o]) begin
        e_rw = rw_i[o]; e_regin = regin[o]; e_addr = addr_i[o]; e_data = data_i[o];
        if (rw_i[o] && addr_i[o] == 3'd0) begin
          o_valid = regin[o];
          if (regin[o]) o_id = o[0];
        end
      end else begin
        e_rw = 1'b0; e_regin = 1'b0; e_addr = 3'd0;
      end
      if (o < 0) begin
        if (req[0] || req[1]) begin
          int w;
          w = (req[0] && req[1]) ? (m_last ? 0 : 1) : (req[1] ? 1 : 0);
          m_owner = w; m_last = w[0]; m_held = 0;
        end
      end else begin
        if (!lock[o] && (!req[o] || (m_held >= int'(HOLD_MAX) - 1 && req[1-o])))
          m_owner = -1;
        else
          m_held++;
      end
    end
  endtask

  task automatic compare_all();
    chk("m0_gnt", m0_gnt, m_owner == 0);
    chk("m1_gnt", m1_gnt, m_owner == 1);
    chk("rw", rw, e_rw);
    chk("reg_in", reg_in, e_regin);
    chk("addr", addr, e_addr);
    chk("data_out", data_out, e_data);
    chk("m0_reg_out", m0_reg_out, reg_out && m_owner == 0);
    chk("m1_reg_out", m1_reg_out, reg_out && m_owner == 1);
    chk("m0_irq", m0_irq, (o_valid && o_id == 1'b0) ? irq : 1'b1);
    chk("m1_irq", m1_irq, (o_valid && o_id == 1'b1) ? irq : 1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
    compare_all();
  endtask

  initial begin
    int run, gap, waited;
    bit seen_first;
    rst = 1'b1; reg_out = 1'b0; irq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b1; lock[i] = 1'b0; rw_i[i] = 1'b0; regin[i] = 1'b0;
      addr_i[i] = 3'd0; data_i[i] = 8'd0;
    end

    // Reset with both masters requesting.
    repeat (3) step();
    chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);
    chk("rst_data", data_out, 8'h00);
    chk("rst_irq", {m1_irq, m0_irq}, 2'b11);
    rst = 1'b0;
    step();
    chk("first_gnt_m0", {m1_gnt, m0_gnt}, 2'b01);

    // Single m0 write, then release; m1 takes over after one gap cycle.
    rw_i[0] = 1'b1; addr_i[0] = 3'd1; data_i[0] = 8'h48; reg_out = 1'b1;
    step();
    chk("wr_pins", {rw, addr, data_out}, {1'b1, 3'd1, 8'h48});
    req[0] = 1'b0; rw_i[0] = 1'b0;
    step();
    chk("gap_pins", {m1_gnt, m0_gnt, rw}, 3'b000);
    step();
    chk("m1_after_gap", m1_gnt, 1'b1);
    chk("data_held", data_out, 8'h48);

    // Continuous contention: full grants of HOLD_MAX cycles with single-cycle gaps.
    req[0] = 1'b1;
    run = 0; gap = 0; seen_first = 1'b0;
    for (int c = 0; c < 400; c++) begin
      step();
      if (m0_gnt || m1_gnt) begin
        if (gap > 0) chk("gap_len", gap, 1);
        gap = 0;
        run++;
      end else begin
        if (run > 0 && seen_first) chk("hold_len", run, HOLD_MAX);
        if (run > 0) seen_first = 1'b1;
        run = 0;
        gap++;
      end
    end

    // Lock keeps m0 on the bus despite m1 waiting and m0 dropping req.
    waited = 0;
    while (!m0_gnt && waited < 200) begin step(); waited++; end
    chk("wait_m0_gnt", m0_gnt, 1'b1);
    lock[0] = 1'b1; req[0] = 1'b0; req[1] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      chk("lock_hold", {m1_gnt, m0_gnt, rw}, 3'b010);
    end
    lock[0] = 1'b0;
    step();
    chk("unlock_gap", {m1_gnt, m0_gnt}, 2'b00);
    step();
    chk("unlock_m1", m1_gnt, 1'b1);

    // m1 takes interrupt mode, then releases it.
    irq = 1'b0;
    rw_i[1] = 1'b1; addr_i[1] = 3'd0; regin[1] = 1'b1; data_i[1] = 8'h5a;
    step();
    chk("irq_own", {m1_irq, m0_irq}, 2'b01);
    rw_i[1] = 1'b0;
    step();
    chk("irq_own_hold", m1_irq, 1'b0);
    rw_i[1] = 1'b1; regin[1] = 1'b0;
    step();
    chk("irq_clear", {m1_irq, m0_irq}, 2'b11);
    rw_i[1] = 1'b0;

    // Non-granted m1 driving writes never reaches the POC.
    req[1] = 1'b0; req[0] = 1'b1;
    rw_i[1] = 1'b1; data_i[1] = 8'hff; addr_i[1] = 3'd0; regin[1] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk("m1_blocked", {m1_reg_out, rw}, 2'b00);
    end

    // Random traffic, including occasional resets and locks.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(19) == 0) req[i] = ~req[i];
        if ($urandom_range(39) == 0) lock[i] = ~lock[i];
        rw_i[i]   = $urandom_range(1);
        regin[i]  = $urandom_range(1);
        addr_i[i] = ($urandom_range(2) == 0) ? 3'd0 : 3'($urandom_range(7));
        data_i[i] = 8'($urandom);
      end
      if (lock[0] && lock[1]) lock[$urandom_range(1)] = 1'b0;
      if ($urandom_range(7) == 0) irq = $urandom_range(1);
      reg_out = $urandom_range(1);
      rst = ($urandom_range(399) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
